// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card emulator: oversamples the host link on clk, decodes CMD0/8/55/41/58/17
// and answers on miso; CMD17 data is streamed from a byte-wide synchronous memory port.
module sd_spi_card_responder #(
  parameter int ACMD41_POLLS = 2,
  parameter int NCR_BYTES    = 1,
  parameter int NAC_BYTES    = 2,
  parameter bit CRC_CHECK    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  output logic [31:0] blk_addr,
  output logic [8:0]  byte_idx,
  output logic        byte_rd_en,
  input  logic [7:0]  byte_data,
  output logic        card_idle,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index
);
  typedef enum logic [3:0] {IDLE, HUNT, CMD_RX, NCR, RESP, NAC, TOKEN, DATA, CRC} state_t;

  localparam logic [7:0] POLLS    = 8'(ACMD41_POLLS);
  localparam logic [9:0] NCR_LAST = 10'(NCR_BYTES - 1);
  localparam logic [9:0] NAC_LAST = 10'(NAC_BYTES - 1);

  state_t      state, state_nxt;
  logic [1:0]  sclk_sync, cs_sync, mosi_sync;
  logic        sclk_prev, cs_prev, cs_hi, cs_fall, sclk_rise, sclk_fall, byte_done;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [7:0]  rx_byte, tx_sr, tx_nxt, data_buf, r1_q, poll_cnt, r1;
  logic [39:0] cmd_sr;
  logic [9:0]  cnt, cnt_nxt;
  logic [31:0] tail_q, tail, arg;
  logic [5:0]  idx;
  logic        spi_mode, app_cmd, long_q, read_q, rd_dly;
  logic        drop, crc_bad, long_resp, do_cmd0, do_app, do_poll, do_ready, do_read;
  logic        tx_ld, rd_nxt, frame_end, blk_end;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign cs_hi     = cs_sync[1];
  assign cs_fall   = ~cs_sync[1] & cs_prev;
  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;
  assign byte_done = sclk_rise & ~cs_hi & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr, mosi_sync[1]};
  assign miso      = tx_sr[7];

  // Frame fields: bytes 0..4 sit in cmd_sr, byte 5 is the byte just completed.
  assign idx     = cmd_sr[37:32];
  assign arg     = cmd_sr[31:0];
  assign drop    = ~rx_byte[0] | (~spi_mode & (idx != 6'd0));
  assign crc_bad = (CRC_CHECK || idx == 6'd0 || idx == 6'd8) && (crc7(cmd_sr) != rx_byte[7:1]);

  always_comb begin
    r1 = {7'b0, card_idle};
    tail = 32'h0;
    long_resp = 1'b0;
    do_cmd0 = 1'b0;
    do_app = 1'b0;
    do_poll = 1'b0;
    do_ready = 1'b0;
    do_read = 1'b0;
    if (crc_bad) begin
      r1 = {4'b0, 1'b1, 2'b0, card_idle};
    end else begin
      case (idx)
        6'd0: begin r1 = 8'h01; do_cmd0 = 1'b1; end
        6'd8: begin
          if (arg[11:8] == 4'h1) begin
            r1 = 8'h01;
            tail = {20'h0, arg[11:8], arg[7:0]};
            long_resp = 1'b1;
          end else begin
            r1 = 8'h05;
          end
        end
        6'd55: do_app = 1'b1;
        6'd41: begin
          if (!app_cmd)              r1 = {5'b0, 1'b1, 1'b0, card_idle};
          else if (poll_cnt < POLLS) begin r1 = 8'h01; do_poll = 1'b1; end
          else                       begin r1 = 8'h00; do_ready = 1'b1; end
        end
        6'd58: begin tail = 32'hC0FF_8000; long_resp = 1'b1; end
        6'd17: begin
          if (card_idle) r1 = 8'h05;
          else begin r1 = 8'h00; do_read = 1'b1; end
        end
        default: r1 = {5'b0, 1'b1, 1'b0, card_idle};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Each byte boundary picks the byte for the next slot; the strobe for data byte k+1
  // goes out as byte k starts so the memory has a full byte time to answer.
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    tx_ld = 1'b0;
    tx_nxt = 8'hFF;
    rd_nxt = 1'b0;
    frame_end = 1'b0;
    blk_end = 1'b0;
    if (cs_hi) begin
      state_nxt = IDLE;
      cnt_nxt = '0;
      tx_ld = 1'b1;
    end else if (state == IDLE) begin
      state_nxt = HUNT;
    end else if (byte_done) begin
      tx_ld = 1'b1;
      cnt_nxt = cnt + 10'd1;
      case (state)
        HUNT: if (rx_byte[7:6] == 2'b01) begin state_nxt = CMD_RX; cnt_nxt = 10'd1; end
        CMD_RX: if (cnt == 10'd5) begin
          frame_end = 1'b1;
          cnt_nxt = '0;
          state_nxt = drop ? HUNT : NCR;
        end
        NCR: if (cnt == NCR_LAST) begin state_nxt = RESP; cnt_nxt = '0; tx_nxt = r1_q; end
        RESP: begin
          if (cnt == (long_q ? 10'd4 : 10'd0)) begin
            cnt_nxt = '0;
            state_nxt = read_q ? NAC : HUNT;
          end else begin
            tx_nxt = tail_q[31:24];
          end
        end
        NAC: if (cnt == NAC_LAST) begin
          state_nxt = TOKEN; cnt_nxt = '0; tx_nxt = 8'hFE; rd_nxt = 1'b1;
        end
        TOKEN: begin state_nxt = DATA; cnt_nxt = '0; tx_nxt = data_buf; rd_nxt = 1'b1; end
        DATA: begin
          if (cnt == 10'd511) begin
            state_nxt = CRC; cnt_nxt = '0; blk_end = 1'b1;
          end else begin
            tx_nxt = data_buf;
            rd_nxt = (cnt < 10'd510);
          end
        end
        CRC: if (cnt == 10'd1) begin state_nxt = HUNT; cnt_nxt = '0; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= 2'b00;  cs_sync <= 2'b11;  mosi_sync <= 2'b11;
      sclk_prev <= 1'b0;   cs_prev <= 1'b1;
      bit_cnt <= '0;  rx_sr <= '0;  tx_sr <= 8'hFF;  cmd_sr <= '0;  cnt <= '0;
      data_buf <= '0;  rd_dly <= 1'b0;  byte_rd_en <= 1'b0;  byte_idx <= '0;
      blk_addr <= '0;  cmd_valid <= 1'b0;  cmd_index <= '0;  card_idle <= 1'b1;
      spi_mode <= 1'b0;  app_cmd <= 1'b0;  poll_cnt <= '0;
      r1_q <= 8'hFF;  tail_q <= '0;  long_q <= 1'b0;  read_q <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_clk};
      cs_sync   <= {cs_sync[0], cs};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_prev <= sclk_sync[1];
      cs_prev   <= cs_sync[1];
      if (cs_hi || cs_fall) bit_cnt <= '0;
      else if (sclk_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sr   <= rx_byte[6:0];
      end
      // No shift on the fall right after a boundary: the new MSB must stay for the next rise.
      if (tx_ld) tx_sr <= tx_nxt;
      else if (sclk_fall && !cs_hi && bit_cnt != 3'd0) tx_sr <= {tx_sr[6:0], 1'b1};
      cnt <= cnt_nxt;
      if (byte_done && (state == HUNT || (state == CMD_RX && cnt != 10'd5)))
        cmd_sr <= {cmd_sr[31:0], rx_byte};
      if (state == RESP && byte_done) tail_q <= {tail_q[23:0], 8'h00};
      byte_rd_en <= rd_nxt;
      rd_dly     <= byte_rd_en;
      if (rd_dly) data_buf <= byte_data;
      if (rd_nxt)       byte_idx <= (state == NAC) ? 9'd0 : byte_idx + 9'd1;
      else if (blk_end) byte_idx <= 9'd0;
      cmd_valid <= frame_end & ~drop;
      if (frame_end) begin
        app_cmd <= ~drop & do_app;
        if (!drop) begin
          cmd_index <= idx;
          r1_q <= r1;
          tail_q <= tail;
          long_q <= long_resp;
          read_q <= do_read;
          if (do_cmd0) begin spi_mode <= 1'b1; card_idle <= 1'b1; poll_cnt <= '0; end
          if (do_poll)  poll_cnt <= poll_cnt + 8'd1;
          if (do_ready) card_idle <= 1'b0;
          if (do_read)  blk_addr <= arg;
        end
      end
    end
  end
endmodule
